// File: rtl/rle_encoder_pkg.sv
// Shared definitions for the run-length encoder/decoder pair: default widths
// and the FSM state encoding.
package rle_encoder_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned RUN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/rle_encoder.sv
// Run-length encoder: turns a stream of signed coefficients into (value, run)
// pairs, closing the open run at every frame boundary.
module rle_encoder
    import rle_encoder_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RUN_W  = RUN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_value,
    output logic [RUN_W-1:0]  out_run,
    output logic              out_last
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    state_t            state;
    logic [DATA_W-1:0] cur_val;
    logic [RUN_W-1:0]  cur_cnt;
    logic [DATA_W-1:0] pend_val;

    logic slot_free;
    logic accept;
    logic extend;

    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = slot_free && (state != FLUSH);
        accept    = in_valid && in_ready;
        // A saturated run never absorbs another sample, even an equal one.
        extend    = (in_data == cur_val) && (cur_cnt != RUN_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_val   <= '0;
            cur_cnt   <= '0;
            pend_val  <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_run   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_last) begin
                            out_valid <= 1'b1;
                            out_value <= in_data;
                            out_run   <= RUN_ONE;
                            out_last  <= 1'b1;
                        end else begin
                            cur_val <= in_data;
                            cur_cnt <= RUN_ONE;
                            state   <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (accept) begin
                        if (extend && !in_last) begin
                            cur_cnt <= cur_cnt + RUN_ONE;
                        end else if (extend) begin
                            out_valid <= 1'b1;
                            out_value <= cur_val;
                            out_run   <= cur_cnt + RUN_ONE;
                            out_last  <= 1'b1;
                            cur_cnt   <= '0;
                            state     <= IDLE;
                        end else begin
                            out_valid <= 1'b1;
                            out_value <= cur_val;
                            out_run   <= cur_cnt;
                            out_last  <= 1'b0;
                            if (in_last) begin
                                // New sample is a complete one-long run; park it
                                // until the slot frees.
                                pend_val <= in_data;
                                cur_cnt  <= '0;
                                state    <= FLUSH;
                            end else begin
                                cur_val <= in_data;
                                cur_cnt <= RUN_ONE;
                            end
                        end
                    end
                end

                FLUSH: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_value <= pend_val;
                        out_run   <= RUN_ONE;
                        out_last  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_encoder.sv
// Directed and randomized bench for rle_encoder against a queue-based
// run-length reference model.
module tb_rle_encoder;

    typedef struct packed {
        logic       last;
        logic [7:0] run;
        logic [7:0] val;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_value;
    logic [7:0] out_run;
    logic       out_last;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    pair_t exp_q[$];
    pair_t obs_q[$];

    bit          m_open = 0;
    logic [7:0]  m_val  = '0;
    int unsigned m_cnt  = 0;

    bit    rand_ready = 0;
    bit    stall_prev = 0;
    pair_t prev_pair;

    rle_encoder #(.DATA_W(8), .RUN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_run   (out_run),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Reference: runs of equal values, capped at 255, always closed by last.
    task automatic model_sample(input logic [7:0] d, input logic l);
        if (m_open && d == m_val && m_cnt < 255) begin
            m_cnt++;
        end else begin
            if (m_open) exp_q.push_back('{1'b0, 8'(m_cnt), m_val});
            m_open = 1;
            m_val  = d;
            m_cnt  = 1;
        end
        if (l) begin
            exp_q.push_back('{1'b1, 8'(m_cnt), m_val});
            m_open = 0;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_pair", 32'({out_last, out_run, out_value}), 32'(prev_pair));
            end
            if (out_valid && out_ready) obs_q.push_back('{out_last, out_run, out_value});
            stall_prev = out_valid && !out_ready;
            prev_pair  = '{out_last, out_run, out_value};
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 2000) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        if (n > 2000) chk("send_timeout", 32'(n), 32'd0);
        else model_sample(d, l);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        while (obs_q.size() < exp_q.size() && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_pair%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] vals[4];
        logic [7:0] v;
        int unsigned len;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_value", 32'(out_value), 32'd0);
        chk("rst_run", 32'(out_run), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic frame with FLUSH bubble after the last sample.
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h05, 0); send(8'h05, 0); send(8'hFB, 1);
        @(negedge clk);
        chk("flush_bubble", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("flush_resume", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drain("frame1");

        // Saturation at 255.
        repeat (300) send(8'h00, 0);
        send(8'h07, 1);
        drain("sat300");

        // Exactly 256 equal samples with last on the final one.
        repeat (255) send(8'h44, 0);
        send(8'h44, 1);
        drain("sat_last");

        send(8'h3C, 0); send(8'h3C, 1); send(8'h3C, 1);
        drain("no_merge");

        send(8'h80, 1); send(8'h7F, 1);
        drain("sign_ext");

        // Backpressure with a pair held in the output register.
        out_ready = 1'b0;
        send(8'h11, 0); send(8'h22, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_pair", 32'({out_valid, out_last, out_run, out_value}),
                32'({1'b1, 1'b0, 8'd1, 8'h11}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h33, 1);
        drain("stall");

        // Reset mid-run drops the open run.
        repeat (4) send(8'h12, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_open = 0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_pair", 32'({out_last, out_run, out_value}), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(8'h12, 1);
        drain("after_rst");

        // Randomized frames with random backpressure.
        rand_ready = 1;
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h80; vals[3] = 8'h01;
        for (int f = 0; f < 40; f++) begin
            len = (f == 17) ? 270 : $urandom_range(1, 30);
            v = vals[$urandom_range(0, 3)];
            for (int unsigned k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) != 0) ?
                    8'($urandom) : vals[$urandom_range(0, 3)];
                send(v, k == len - 1);
            end
        end
        drain("random");
        rand_ready = 0;
        out_ready  = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
